bram_stack_ctrl: RTL
====================

# bram_stack_ctrl

LIFO controller that sequences the 9-bit-wide `sdp_bram` as the calculator's operand/token stack and shares it between two requesters: the keypad entry path (port 0) and the expression evaluator (port 1). It owns the stack pointer, converts push/pop/peek/clear requests into correctly timed BRAM write and read cycles, and absorbs the BRAM's one-cycle read latency. It flags overflow and underflow instead of corrupting the pointer, and publishes occupancy for the LED/status logic.

## Interface
- `DW`, 9, data width (matches BRAM word)
- `DEPTH`, 2048, stack entries
- `AW`, 11, BRAM address width, `2**AW >= DEPTH`
- `CLK` in 1: clock
- `RSTN` in 1: reset, synchronous, active-low
- `r0_req`, `r1_req` in 1: request, held until ack
- `r0_op`, `r1_op` in 2: 00 push, 01 pop, 10 peek, 11 clear
- `r0_wdata`, `r1_wdata` in DW: push data
- `r0_ack`, `r1_ack` out 1: one-cycle grant/complete pulse
- `rdata` out DW: pop/peek result
- `rvalid` out 1: one-cycle pulse, `rdata` valid
- `rid` out 1: requester that owns `rdata`
- `ovf`, `unf` out 1: one-cycle error pulses
- `count` out AW+1: current occupancy
- `empty`, `full` out 1: `count==0`, `count==DEPTH`
- `ram_ena`, `ram_wea`, `ram_enb` out 1: BRAM enables
- `ram_addra`, `ram_addrb` out AW: BRAM addresses
- `ram_dia` out DW: BRAM write data
- `ram_dob` in DW: BRAM read data, registered inside BRAM, valid the cycle after `ram_enb`

## Operation
- FSM states: IDLE, WR, RD, RDCAP, NOP. Grants are made only in IDLE.
- Arbitration in IDLE:
  - Exactly one `req` high: grant it.
  - Both high: grant the requester not granted last (`last_grant`, reset to 1, so port 0 wins the first tie).
  - Latch `op`, `wdata`, and id at the grant edge.
- Legal push (`!full`): go to WR.
  - `ram_addra<=count[AW-1:0]`, `ram_dia<=wdata`, `ram_ena<=1`, `ram_wea<=1`, `count<=count+1`.
- Legal pop (`!empty`): go to RD.
  - `ram_addrb<=count-1`, `ram_enb<=1`, `count<=count-1`.
- Legal peek (`!empty`): same as pop, but `count` is unchanged.
- Clear: `count<=0`; go to NOP. BRAM contents are untouched.
- Push when full: `ovf<=1`; go to NOP. Pointer and BRAM are unchanged.
- Pop or peek when empty: `unf<=1`; go to NOP. No `rvalid`.
- Each of WR, RD and NOP lasts one cycle.
  - The ack of the granted port is high during that cycle.
  - BRAM enables are high during WR or RD only and deassert on exit.
- WR → IDLE. NOP → IDLE. RD → RDCAP.
- RDCAP → IDLE. At exit, `rdata<=ram_dob`, `rvalid<=1`, `rid<=latched id`.
- `count` never wraps: saturation is handled by the error path.
- `full` and `empty` are combinational from `count`.

## Timing
- Reset: state IDLE; `count=0`, `last_grant=1`; every output register is 0 (acks, `rvalid`, `rid`, `rdata`, `ovf`, `unf`, all `ram_*`). `empty=1`, `full=0`.
- Request sampled at edge E0 → ack high for E0..E1, and the requester drops `req` at E1.
- Push: BRAM write commits at E1. `count` updates at E0.
- Pop/peek: `ram_enb` high E0..E1, `ram_dob` valid E1..E2, `rvalid`/`rdata` high E2..E3.
- Throughput: push or clear every 2 cycles; pop/peek every 3 cycles. A request that is still high in IDLE is eligible immediately.
- A `req` that is deasserted before ack is a protocol violation with undefined result. `op` and `wdata` are ignored after the grant edge.
- `rvalid` of one pop may coincide with the next grant. The two are independent.
- Reset mid-operation: the state aborts to IDLE at the reset edge and all pulses clear. Stack contents are invalidated logically (`count=0`).

## Test plan
- Port 0 pushes 0x060, 0x0DA, 0x0F2, then pops 3 times → `rdata` 0x0F2, 0x0DA, 0x060, each with `rid=0`; `count` goes 3→0, `empty=1`.
- Both ports request push in the same cycle after reset → port 0 acked first, port 1 acked 2 cycles later. The next tie is won by port 0.
- Pop on empty stack → `unf` pulse, ack, no `rvalid`, `count` stays 0.
- Fill to DEPTH=2048, then push 0x1FF → `full=1`, `ovf` pulse, `count=2048`. A pop then returns the 2048th pushed value.
- Push 0x0B6, peek twice → `rdata=0x0B6` both times with `count=1`. Clear → `count=0`, and a later pop raises `unf`.
- Assert RSTN low during RD → no `rvalid`; state IDLE; all outputs 0 the next cycle; `count=0`.

Source files
------------

// File: rtl/bram_stack_ctrl.sv
// bram_stack_ctrl: two-requester LIFO controller sequencing an sdp_bram as the operand/token stack.
//   CLK/RSTN            : clock, synchronous active-low reset
//   r{0,1}_req/op/wdata : requests (00 push, 01 pop, 10 peek, 11 clear), held until ack
//   r{0,1}_ack          : one-cycle grant/complete pulse
//   rdata/rvalid/rid    : pop/peek result, valid pulse, owning requester
//   ovf/unf             : one-cycle overflow/underflow pulses
//   count/empty/full    : occupancy
//   ram_*               : BRAM port A (write) and port B (read, one-cycle latency)
module bram_stack_ctrl #(
  parameter int DW    = 9,
  parameter int DEPTH = 2048,
  parameter int AW    = 11
) (
  input  logic          CLK,
  input  logic          RSTN,
  input  logic          r0_req,
  input  logic          r1_req,
  input  logic [1:0]    r0_op,
  input  logic [1:0]    r1_op,
  input  logic [DW-1:0] r0_wdata,
  input  logic [DW-1:0] r1_wdata,
  output logic          r0_ack,
  output logic          r1_ack,
  output logic [DW-1:0] rdata,
  output logic          rvalid,
  output logic          rid,
  output logic          ovf,
  output logic          unf,
  output logic [AW:0]   count,
  output logic          empty,
  output logic          full,
  output logic          ram_ena,
  output logic          ram_wea,
  output logic          ram_enb,
  output logic [AW-1:0] ram_addra,
  output logic [AW-1:0] ram_addrb,
  output logic [DW-1:0] ram_dia,
  input  logic [DW-1:0] ram_dob
);
  typedef enum logic [2:0] {IDLE, WR, RD, RDCAP, NOP} state_t;
  state_t        state_q;
  logic [AW:0]   count_q;
  logic          last_grant_q;
  logic          id_q;
  logic          sel_d;
  logic [1:0]    op_d;
  logic [DW-1:0] wdata_d;
  // On a tie, the port not served last wins; otherwise whichever port is requesting.
  always_comb begin
    sel_d   = (r0_req && r1_req) ? !last_grant_q : r1_req;
    op_d    = sel_d ? r1_op : r0_op;
    wdata_d = sel_d ? r1_wdata : r0_wdata;
  end
  assign count = count_q;
  assign empty = (count_q == '0);
  assign full  = (count_q == (AW+1)'(DEPTH));
  always_ff @(posedge CLK) begin
    if (!RSTN) begin
      state_q      <= IDLE;
      count_q      <= '0;
      last_grant_q <= 1'b1;
      id_q         <= 1'b0;
      r0_ack       <= 1'b0;
      r1_ack       <= 1'b0;
      rdata        <= '0;
      rvalid       <= 1'b0;
      rid          <= 1'b0;
      ovf          <= 1'b0;
      unf          <= 1'b0;
      ram_ena      <= 1'b0;
      ram_wea      <= 1'b0;
      ram_enb      <= 1'b0;
      ram_addra    <= '0;
      ram_addrb    <= '0;
      ram_dia      <= '0;
    end else begin
      // Every pulse output lasts exactly one cycle unless re-armed below.
      r0_ack  <= 1'b0;
      r1_ack  <= 1'b0;
      rvalid  <= 1'b0;
      ovf     <= 1'b0;
      unf     <= 1'b0;
      ram_ena <= 1'b0;
      ram_wea <= 1'b0;
      ram_enb <= 1'b0;
      case (state_q)
        IDLE: if (r0_req || r1_req) begin
          last_grant_q <= sel_d;
          id_q         <= sel_d;
          r0_ack       <= !sel_d;
          r1_ack       <= sel_d;
          if (op_d == 2'b11) begin
            count_q <= '0;
            state_q <= NOP;
          end else if (op_d == 2'b00) begin
            if (full) begin
              ovf     <= 1'b1;
              state_q <= NOP;
            end else begin
              ram_addra <= count_q[AW-1:0];
              ram_dia   <= wdata_d;
              ram_ena   <= 1'b1;
              ram_wea   <= 1'b1;
              count_q   <= count_q + 1'b1;
              state_q   <= WR;
            end
          end else if (empty) begin
            unf     <= 1'b1;
            state_q <= NOP;
          end else begin
            ram_addrb <= AW'(count_q - 1'b1);
            ram_enb   <= 1'b1;
            count_q   <= (op_d == 2'b01) ? count_q - 1'b1 : count_q;
            state_q   <= RD;
          end
        end
        RD: state_q <= RDCAP;
        // BRAM output register holds the word now; capture it for the requester.
        RDCAP: begin
          rdata   <= ram_dob;
          rvalid  <= 1'b1;
          rid     <= id_q;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule
